// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer write path.
//   PIX_W       gray pixel width carried from compute engine to framebuffer
//   fb_state_t  write sequencer state encoding
package fb_pkg;

  localparam int unsigned PIX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PTR_RST,
    FETCH,
    STROBE,
    WAIT_ACK,
    GAP
  } fb_state_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// fb_pixel_fifo: synchronous pixel buffer between compute engine and the
// framebuffer write sequencer. DEPTH must be a power of two, at least 2.
//   clk, rst   clock and synchronous active-high reset
//   flush      empties the buffer (wins over a same-cycle push)
//   push       write push_data (ignored when full unless popping too)
//   pop        drop head entry (ignored when empty)
//   head       current head entry, valid when !empty
//   full/empty occupancy flags
//   count      current occupancy, 0..DEPTH
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = PIX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full buffer can still take a push.
  assign do_push = push && (!full || do_pop);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_write_sequencer.sv
// fb_write_sequencer: accepts a frame of gray pixels from the compute engine,
// buffers them and writes them one at a time to the framebuffer with a
// strobe/acknowledge handshake. All outputs are registered.
//   clk, rst         clock and synchronous active-high reset
//   start            one-cycle request to write a new frame (ignored while busy)
//   pix_valid/ready  pixel handshake from the compute engine, pix_data value
//   write_data_in    pixel value presented to the framebuffer write port
//   write_data       one-cycle write strobe
//   reset_write_ptr  rewinds the framebuffer write pointer at frame start
//   wrote_data       write acknowledge, honoured only while waiting for it
//   busy             high whenever not idle
//   frame_done       one-cycle pulse once the last pixel is acknowledged
//   ack_err          sticky: some acknowledge in this frame timed out
module fb_write_sequencer
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_W        = 320,
  parameter int unsigned FRAME_H        = 240,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PTR_RST_CYCLES = 4,
  parameter int unsigned WRITE_GAP      = 2,
  parameter int unsigned ACK_TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [PIX_W-1:0] write_data_in,
  output logic             write_data,
  output logic             reset_write_ptr,
  input  logic             wrote_data,
  output logic             busy,
  output logic             frame_done,
  output logic             ack_err
);

  localparam int unsigned TOTAL = FRAME_W * FRAME_H;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  localparam int unsigned FAW   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW   = FAW + 1;
  localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

  // Last timer value of each timed state; a zero-length setting still costs one cycle.
  localparam int unsigned PTR_LAST = (PTR_RST_CYCLES > 1) ? PTR_RST_CYCLES - 1 : 0;
  localparam int unsigned ACK_LAST = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 0;
  localparam int unsigned GAP_LAST = (WRITE_GAP > 1) ? WRITE_GAP - 1 : 0;
  localparam int unsigned TMAX_PA  = (PTR_LAST > ACK_LAST) ? PTR_LAST : ACK_LAST;
  localparam int unsigned TMAX     = (TMAX_PA > GAP_LAST) ? TMAX_PA : GAP_LAST;
  localparam int unsigned TW       = $clog2(TMAX + 2);
  localparam logic [TW-1:0] PTR_LAST_C = TW'(PTR_LAST);
  localparam logic [TW-1:0] ACK_LAST_C = TW'(ACK_LAST);
  localparam logic [TW-1:0] GAP_LAST_C = TW'(GAP_LAST);

  fb_state_t        state, state_n;
  logic [CW-1:0]    acc_cnt, acc_cnt_n;
  logic [CW-1:0]    wr_cnt, wr_cnt_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic             acc_clear;

  logic             pix_ready_n;
  logic [PIX_W-1:0] write_data_in_n;
  logic             write_data_n;
  logic             reset_write_ptr_n;
  logic             busy_n;
  logic             frame_done_n;
  logic             ack_err_n;

  logic             fifo_flush;
  logic             fifo_push;
  logic             fifo_pop;
  logic [PIX_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [FCW-1:0]   fifo_count_n;

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (pix_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_n         = state;
    wr_cnt_n        = wr_cnt;
    tmr_n           = tmr;
    write_data_in_n = write_data_in;
    ack_err_n       = ack_err;
    frame_done_n    = 1'b0;
    acc_clear       = 1'b0;
    fifo_flush      = 1'b0;
    fifo_pop        = 1'b0;
    fifo_push       = pix_valid && pix_ready && !fifo_full;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = PTR_RST;
          tmr_n      = '0;
          wr_cnt_n   = '0;
          ack_err_n  = 1'b0;
          fifo_flush = 1'b1;
          acc_clear  = 1'b1;
        end
      end
      PTR_RST: begin
        if (tmr >= PTR_LAST_C) state_n = FETCH;
        else                   tmr_n   = tmr + 1'b1;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          write_data_in_n = fifo_head;
          state_n         = STROBE;
        end
      end
      STROBE: begin
        // The acknowledge timeout is measured from the strobe cycle itself.
        state_n = WAIT_ACK;
        tmr_n   = TW'(1);
      end
      WAIT_ACK: begin
        if (wrote_data || (tmr >= ACK_LAST_C)) begin
          if (!wrote_data) ack_err_n = 1'b1;
          state_n  = GAP;
          tmr_n    = '0;
          wr_cnt_n = wr_cnt + 1'b1;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      GAP: begin
        if (tmr >= GAP_LAST_C) begin
          if (wr_cnt >= TOTAL_C) begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    acc_cnt_n = acc_clear ? '0 : acc_cnt + CW'(fifo_push);

    // pix_ready is registered, so it is derived from next-cycle occupancy and
    // acceptance count to stay exact when push and pop coincide.
    fifo_count_n = fifo_flush ? '0
                 : fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);

    busy_n            = (state_n != IDLE);
    write_data_n      = (state_n == STROBE);
    reset_write_ptr_n = (state_n == PTR_RST);
    pix_ready_n       = busy_n && (fifo_count_n < DEPTH_C) && (acc_cnt_n < TOTAL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc_cnt         <= '0;
      wr_cnt          <= '0;
      tmr             <= '0;
      pix_ready       <= 1'b0;
      write_data_in   <= '0;
      write_data      <= 1'b0;
      reset_write_ptr <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      ack_err         <= 1'b0;
    end else begin
      state           <= state_n;
      acc_cnt         <= acc_cnt_n;
      wr_cnt          <= wr_cnt_n;
      tmr             <= tmr_n;
      pix_ready       <= pix_ready_n;
      write_data_in   <= write_data_in_n;
      write_data      <= write_data_n;
      reset_write_ptr <= reset_write_ptr_n;
      busy            <= busy_n;
      frame_done      <= frame_done_n;
      ack_err         <= ack_err_n;
    end
  end

endmodule
